hard_decode_scheduler: RTL and testbench
========================================

# hard_decode_scheduler

Shares one hard-decision decode container between `NUM_REQ` requesters. Requesters are served in round-robin order. For each accepted job the block latches the codeword and its code parameters (N, n, a), pulses the container's start, and waits for its done. It then returns the ±2^23 soft-value vector to the requester over a valid/ready handshake, tagged with requester id and a status code. It sits between the read-channel front ends and the single shared decoder instance.

## Interface
- `DATA_WIDTH`, 32, codeword width and number of output soft values.
- `NUM_REQ`, 4, number of requesters (2..16).
- `TIMEOUT`, 1024, maximum cycles to wait for decoder done.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `req_data`  in  NUM_REQ×DATA_WIDTH  received codewords.
- `req_N`, `req_n`, `req_a`  in  NUM_REQ×32 each  code parameters, signed int.
- `dec_start`  out  1  one-cycle start to the container.
- `dec_data`  out  DATA_WIDTH  latched codeword.
- `dec_N`, `dec_n`, `dec_a`  out  32 each  latched parameters, held stable from START through RESP.
- `dec_out`  in  DATA_WIDTH×32 signed  container soft outputs.
- `dec_done`  in  1  container completion pulse.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  $clog2(NUM_REQ)  requester index.
- `rsp_status`  out  2  00 OK, 01 BAD_PARAM, 10 TIMEOUT.
- `rsp_data`  out  DATA_WIDTH×32 signed  captured soft values; all-zero unless status OK.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CHECK, START, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Pulse `req_ready[g]` for one cycle, latch that requester's data/N/n/a and id, then go to CHECK.
- **CHECK:**
  - Parameters are legal when `1 <= N <= DATA_WIDTH` and `n >= 0`. Legal parameters go to START.
  - Illegal parameters go to RESP with status BAD_PARAM and zero data. The decoder is never started.
- **START:** assert `dec_start` for exactly one cycle, clear the wait counter, go to WAIT.
- **WAIT:**
  - On the first cycle `dec_done` is high, capture `dec_out` into `rsp_data` with status OK, then go to RESP.
  - If the counter reaches `TIMEOUT` first, set status TIMEOUT with zero data, then go to RESP.
  - If `dec_done` and the timeout coincide, `dec_done` wins.
- **RESP:**
  - `rsp_valid` is high and `rsp_*` are held stable until `rsp_ready` is sampled high.
  - On that handshake: set `rr_ptr` to (granted id + 1) mod NUM_REQ and go to IDLE.
- The block holds no job queue. Requesters keep `req_valid` and their inputs stable until `req_ready`.
- `dec_done` outside WAIT is ignored.
- Wait counter is 32-bit, saturating.

## Timing
- **Reset values:**
  - Outputs: `req_ready`=0, `dec_start`=0, `dec_data`/`dec_N`/`dec_n`/`dec_a`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_status`=00, `rsp_data`=0, `busy`=0.
  - Internal: FSM in IDLE, `rr_ptr`=0.
- Reset asserted mid-job aborts the job immediately. No response is produced and `dec_start` is not re-issued.
- **Latency, cycles after the accept edge:**
  - CHECK is +1 and START (`dec_start` high) is +2.
  - `rsp_valid` rises the cycle after `dec_done` is sampled.
  - For a BAD_PARAM job, `rsp_valid` rises at +2.
- Back-to-back jobs: `req_ready` can fire in the cycle after the response handshake. Minimum job spacing is 4 cycles plus decoder latency.
- All outputs are registered.

## Structure
- Package `dna_dec_pkg` holds:
  - enum `sched_state_t`
  - `rsp_status_t` constants `ST_OK`, `ST_BAD_PARAM`, `ST_TIMEOUT`
  - LLR magnitude constant `LLR_ONE` = 32'sh0080_0000
- Sub-module `rr_arbiter` (parameter N) takes `req` and `ptr` and returns one-hot `grant` plus `grant_idx`, combinationally.

## Test plan
- Single requester 2, `data`=32'h0000_00A5, N=8, n=5, a=0, `dec_done` stubbed 7 cycles after start → `req_ready`=4'b0100; `dec_start` pulses exactly once; `rsp_id`=2, status OK; `rsp_data` equals the stub's vector.
- All four `req_valid` held continuously, with `rsp_ready` always 1 → grant order 0,1,2,3,0 and exactly one `dec_start` per job.
- N=0 (and separately N=33, and n=-1) → no `dec_start`; `rsp_valid` at accept+2 with status 01 and zero data.
- TIMEOUT=16 with `dec_done` never asserted → `rsp_valid` 17 cycles after `dec_start`, status 10; a `dec_done` arriving later is ignored.
- `rsp_ready` held low 10 cycles in RESP while requester 1 is valid → `rsp_*` stay stable, no `req_ready` fires; `req_ready[1]` pulses the cycle after the handshake.
- `rst_n` dropped during WAIT → all outputs at reset values asynchronously; after release, a new request from 0 is served normally.

Source files
------------

// File: rtl/dna_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dna_dec_pkg
//  Brief    : Shared types and constants for the hard-decision decode scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package dna_dec_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } sched_state_t;

   typedef logic [1:0] rsp_status_t;

   localparam rsp_status_t ST_OK        = 2'b00;
   localparam rsp_status_t ST_BAD_PARAM = 2'b01;
   localparam rsp_status_t ST_TIMEOUT   = 2'b10;

   // Soft-value magnitude of a confident hard decision (2^23).
   localparam logic signed [31:0] LLR_ONE = 32'sh0080_0000;

   // A code is decodable when its length fits the container and n is non-negative.
   function automatic logic params_legal(input logic [31:0] code_len,
                                         input logic [31:0] code_n,
                                         input int          max_len);
      return ($signed(code_len) >= 32'sd1) &&
             ($signed(code_len) <= max_len) &&
             ($signed(code_n) >= 32'sd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick of the first request at/after ptr.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW:0] cand;
   logic        found;

   // Walk the requesters starting at ptr; one subtraction wraps since ptr < N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found                 = 1'b1;
            grant[cand[IW-1:0]]   = 1'b1;
            grant_idx             = cand[IW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hard_decode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hard_decode_scheduler
//  Brief    : Round-robin sharing of one hard-decision decode container.
//  Revision : 1.0  initial release
// ============================================================================
module hard_decode_scheduler
   import dna_dec_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REQ    = 4,
   parameter  int TIMEOUT    = 1024,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*32-1:0]         req_N,
   input  logic [NUM_REQ*32-1:0]         req_n,
   input  logic [NUM_REQ*32-1:0]         req_a,
   output logic                          dec_start,
   output logic [DATA_WIDTH-1:0]         dec_data,
   output logic [31:0]                   dec_N,
   output logic [31:0]                   dec_n,
   output logic [31:0]                   dec_a,
   input  logic [DATA_WIDTH*32-1:0]      dec_out,
   input  logic                          dec_done,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [IW-1:0]                 rsp_id,
   output logic [1:0]                    rsp_status,
   output logic [DATA_WIDTH*32-1:0]      rsp_data,
   output logic                          busy
);

   sched_state_t                 state_q, state_d;
   logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]                id_q, id_d;
   logic [NUM_REQ-1:0]           req_ready_q, req_ready_d;
   logic                         dec_start_q, dec_start_d;
   logic [DATA_WIDTH-1:0]        data_q, data_d;
   logic [31:0]                  code_N_q, code_N_d;
   logic [31:0]                  code_n_q, code_n_d;
   logic [31:0]                  code_a_q, code_a_d;
   logic                         rsp_valid_q, rsp_valid_d;
   rsp_status_t                  rsp_status_q, rsp_status_d;
   logic [DATA_WIDTH*32-1:0]     rsp_data_q, rsp_data_d;
   logic [31:0]                  cnt_q, cnt_d;
   logic                         busy_q, busy_d;

   logic [NUM_REQ-1:0]           arb_grant;
   logic [IW-1:0]                arb_idx;
   logic [DATA_WIDTH-1:0]        sel_data;
   logic [31:0]                  sel_N, sel_n, sel_a;
   logic [31:0]                  cnt_inc;
   logic                         par_ok;
   logic                         wait_expired;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign sel_data = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_N    = req_N[arb_idx*32 +: 32];
   assign sel_n    = req_n[arb_idx*32 +: 32];
   assign sel_a    = req_a[arb_idx*32 +: 32];

   assign par_ok       = params_legal(code_N_q, code_n_q, DATA_WIDTH);
   assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
   // Expiry is judged on the count this WAIT cycle would reach.
   assign wait_expired = (cnt_inc >= 32'(TIMEOUT));

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      req_ready_d  = '0;
      dec_start_d  = 1'b0;
      data_d       = data_q;
      code_N_d     = code_N_q;
      code_n_d     = code_n_q;
      code_a_d     = code_a_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_status_d = rsp_status_q;
      rsp_data_d   = rsp_data_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               req_ready_d = arb_grant;
               id_d        = arb_idx;
               data_d      = sel_data;
               code_N_d    = sel_N;
               code_n_d    = sel_n;
               code_a_d    = sel_a;
               state_d     = S_CHECK;
            end
         end
         S_CHECK: begin
            if (par_ok) begin
               dec_start_d = 1'b1;
               state_d     = S_START;
            end else begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_BAD_PARAM;
               rsp_data_d   = '0;
               state_d      = S_RESP;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dec_done) begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_OK;
               rsp_data_d   = dec_out;
               state_d      = S_RESP;
            end else if (wait_expired) begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_TIMEOUT;
               rsp_data_d   = '0;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = (id_q == IW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_d = (state_d != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         req_ready_q  <= '0;
         dec_start_q  <= 1'b0;
         data_q       <= '0;
         code_N_q     <= '0;
         code_n_q     <= '0;
         code_a_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= ST_OK;
         rsp_data_q   <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         req_ready_q  <= req_ready_d;
         dec_start_q  <= dec_start_d;
         data_q       <= data_d;
         code_N_q     <= code_N_d;
         code_n_q     <= code_n_d;
         code_a_q     <= code_a_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_data_q   <= rsp_data_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign dec_start  = dec_start_q;
   assign dec_data   = data_q;
   assign dec_N      = code_N_q;
   assign dec_n      = code_n_q;
   assign dec_a      = code_a_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_status = rsp_status_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hard_decode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hard_decode_scheduler
//  Brief    : Directed table-driven bench for hard_decode_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hard_decode_scheduler;
   import dna_dec_pkg::*;

   localparam int DW = 32;
   localparam int NR = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR*32-1:0]  req_N = '0, req_n = '0, req_a = '0;
   logic              dec_start;
   logic [DW-1:0]     dec_data;
   logic [31:0]       dec_N, dec_n, dec_a;
   logic [DW*32-1:0]  dec_out = '0;
   logic              dec_done_w;
   logic              stub_done = 1'b0;
   logic              late_done = 1'b0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [1:0]        rsp_id;
   logic [1:0]        rsp_status;
   logic [DW*32-1:0]  rsp_data;
   logic              busy;

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;
   int stub_cnt = 0;
   int stub_lat = 0;
   int grant_log[$];

   assign dec_done_w = stub_done | late_done;

   always #5 clk = ~clk;

   hard_decode_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .req_N(req_N), .req_n(req_n), .req_a(req_a),
      .dec_start(dec_start), .dec_data(dec_data),
      .dec_N(dec_N), .dec_n(dec_n), .dec_a(dec_a),
      .dec_out(dec_out), .dec_done(dec_done_w),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_status(rsp_status), .rsp_data(rsp_data), .busy(busy)
   );

   // Hard decision to soft value: bit 1 -> -2^23, bit 0 -> +2^23.
   function automatic logic [DW*32-1:0] soft_vec(input logic [31:0] d);
      logic [DW*32-1:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) r[i*32 +: 32] = d[i] ? -LLR_ONE : LLR_ONE;
      return r;
   endfunction

   // Decoder stub: dec_done is sampled stub_lat cycles after dec_start is sampled.
   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (!rst_n) stub_cnt <= 0;
      else if (dec_start && stub_lat > 0) stub_cnt <= stub_lat;
      else if (stub_cnt == 2) begin
         stub_done <= 1'b1;
         dec_out   <= soft_vec(dec_data);
         stub_cnt  <= 0;
      end else if (stub_cnt > 2) stub_cnt <= stub_cnt - 1;
   end

   always @(posedge clk) begin
      if (dec_start) start_cnt <= start_cnt + 1;
      if (|req_ready) begin
         for (int k = 0; k < NR; k++) if (req_ready[k]) grant_log.push_back(k);
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [31:0] d, input logic [31:0] nn,
                          input logic [31:0] kk, input logic [31:0] aa);
      req_data[id*32 +: 32] = d;
      req_N[id*32 +: 32]    = nn;
      req_n[id*32 +: 32]    = kk;
      req_a[id*32 +: 32]    = aa;
   endtask

   typedef struct {
      int          id;
      logic [31:0] data;
      logic [31:0] cN;
      logic [31:0] cn;
      logic [31:0] ca;
      int          lat;
      logic [1:0]  st;
      int          exp_lat;
   } vec_t;

   // One job end to end; exp_lat counts sample points after the accept edge.
   task automatic run_vec(input vec_t v);
      int j;
      int st0;
      logic [DW*32-1:0] exp_d;
      @(negedge clk);
      stub_lat = v.lat;
      set_req(v.id, v.data, v.cN, v.cn, v.ca);
      req_valid = '0;
      req_valid[v.id] = 1'b1;
      st0 = start_cnt;
      @(negedge clk);
      check("req_ready_onehot", 64'(req_ready), 64'(4'b0001 << v.id));
      check("dec_N_latched", 64'(dec_N), 64'(v.cN));
      check("dec_data_latched", 64'(dec_data), 64'(v.data));
      req_valid = '0;
      j = 1;
      while (!rsp_valid && j < 40) begin
         @(negedge clk);
         j++;
      end
      exp_d = (v.st == ST_OK) ? soft_vec(v.data) : '0;
      check("rsp_latency", 64'(j), 64'(v.exp_lat));
      check("dec_start_count", 64'(start_cnt - st0), (v.st == ST_BAD_PARAM) ? 64'd0 : 64'd1);
      check("rsp_id", 64'(rsp_id), 64'(v.id));
      check("rsp_status", 64'(rsp_status), 64'(v.st));
      check("rsp_data", 64'(rsp_data === exp_d), 64'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[7];
      vec_t v;
      int   st0;
      int   n;
      int   bad;
      int   exp_order[5];
      logic [DW*32-1:0] exp_d;

      vt[0] = '{2, 32'h0000_00A5, 32'd8,  32'd5,         32'd0,         7, ST_OK,        10};
      vt[1] = '{0, 32'h0000_1234, 32'd0,  32'd3,         32'd0,         7, ST_BAD_PARAM, 2};
      vt[2] = '{1, 32'hFFFF_0000, 32'd33, 32'd3,         32'd0,         7, ST_BAD_PARAM, 2};
      vt[3] = '{3, 32'h0000_5A5A, 32'd8,  32'hFFFF_FFFF, 32'd0,         7, ST_BAD_PARAM, 2};
      vt[4] = '{1, 32'hDEAD_BEEF, 32'd32, 32'd0,         32'hFFFF_FFFD, 4, ST_OK,        7};
      vt[5] = '{0, 32'h0000_0001, 32'd1,  32'd0,         32'd2,         2, ST_OK,        5};
      vt[6] = '{2, 32'h0000_0F0F, 32'd16, 32'd4,         32'd1,         0, ST_TIMEOUT,   19};
      exp_order = '{0, 1, 2, 3, 0};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_dec_start", 64'(dec_start), 64'd0);
      check("rst_dec_data", 64'({dec_data, dec_N}), 64'd0);
      check("rst_dec_na", 64'({dec_n, dec_a}), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_id_status", 64'({rsp_id, rsp_status}), 64'd0);
      check("rst_rsp_data", 64'(rsp_data === '0), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      // Round robin with every requester permanently valid.
      @(negedge clk);
      stub_lat = 2;
      for (int i = 0; i < NR; i++) set_req(i, 32'h1111_0000 + 32'(i), 32'd8, 32'd1, 32'd0);
      grant_log.delete();
      st0 = start_cnt;
      rsp_ready = 1'b1;
      req_valid = '1;
      n = 0;
      while (grant_log.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      rsp_ready = 1'b0;
      check("rr_grant_count", 64'(grant_log.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size()) check("rr_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
         else check("rr_grant_order", 64'hDEAD, 64'(exp_order[i]));
      end
      check("rr_dec_start_count", 64'(start_cnt - st0), 64'd5);

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // A dec_done after the timeout response must not produce anything.
      @(negedge clk);
      late_done = 1'b1;
      @(negedge clk);
      late_done = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("late_done_ignored", 64'(bad), 64'd0);

      // Response back-pressure while another requester waits.
      stub_lat = 3;
      set_req(3, 32'h0000_3C3C, 32'd12, 32'd2, 32'd0);
      req_valid = 4'b1000;
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      set_req(1, 32'h0000_0077, 32'd0, 32'd0, 32'd0);
      req_valid = 4'b0010;
      exp_d = soft_vec(32'h0000_3C3C);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_status !== ST_OK ||
             rsp_data !== exp_d || req_ready !== 4'b0000) bad++;
      end
      check("stall_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall_no_early_ready", 64'({rsp_valid, req_ready}), 64'd0);
      @(negedge clk);
      check("stall_next_grant", 64'(req_ready), 64'(4'b0010));
      req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("stall_second_status", 64'({rsp_id, rsp_status}), 64'({2'd1, ST_BAD_PARAM}));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset while waiting on the decoder.
      @(negedge clk);
      stub_lat = 12;
      set_req(2, 32'h0000_00FF, 32'd8, 32'd1, 32'd0);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req_dec", 64'({req_ready, dec_start, rsp_valid, busy}), 64'd0);
      check("arst_dec_regs", 64'({dec_data, dec_N}), 64'd0);
      check("arst_rsp", 64'({rsp_id, rsp_status, 1'(rsp_data === '0)}), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      st0 = start_cnt;
      repeat (4) @(negedge clk);
      check("no_restart_after_reset", 64'({1'(start_cnt != st0), rsp_valid}), 64'd0);
      v = '{0, 32'h8000_0003, 32'd32, 32'd7, 32'd0, 5, ST_OK, 8};
      run_vec(v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
